// File: rtl/gtfraw_lat_stamp_fifo.sv
// Latency timestamp capture: free-running timer stamps TX/RX marker events into paired FIFOs
// and presents the oldest TX/RX pair plus the count of samples still to be collected.
module gtfraw_lat_stamp_fifo #(
  parameter int DEPTH   = 16,
  parameter int TIMER_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               lat_clk,
  input  logic               lat_rst,
  input  logic               lat_enable,
  input  logic               lat_clear,
  input  logic [CNT_W-1:0]   lat_target,
  input  logic               tx_mark,
  input  logic               rx_mark,
  input  logic               lat_pop,
  output logic [TIMER_W-1:0] lat_tx_time,
  output logic [TIMER_W-1:0] lat_rx_time,
  output logic               lat_valid,
  output logic [CNT_W-1:0]   lat_remain,
  output logic               lat_tx_ovf,
  output logic               lat_rx_orph
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [TIMER_W-1:0] timer_r;
  logic [TIMER_W-1:0] tx_mem_r [DEPTH];
  logic [TIMER_W-1:0] rx_mem_r [DEPTH];
  logic [PW-1:0]      tx_wptr_r;
  logic [PW-1:0]      tx_rptr_r;
  logic [PW-1:0]      rx_wptr_r;
  logic [PW-1:0]      rx_rptr_r;
  logic [CNT_W-1:0]   tx_cap_cnt_r;
  logic [CNT_W-1:0]   remain_load_r;

  logic               tx_full_s;
  logic               pair_avail_s;
  logic [PW-1:0]      outstanding_s;
  logic               cap_ok_s;
  logic               tx_acc_s;
  logic               tx_ovf_set_s;
  logic               rx_acc_s;
  logic               rx_orph_set_s;
  logic               pop_acc_s;

  // Acceptance decisions for marks and pops, all from current-cycle state.
  // Read pointers always move together, so wptr difference counts unpaired TX stamps.
  always_comb begin
    tx_full_s     = (tx_wptr_r[AW] != tx_rptr_r[AW]) &&
                    (tx_wptr_r[AW-1:0] == tx_rptr_r[AW-1:0]);
    pair_avail_s  = (tx_wptr_r != tx_rptr_r) && (rx_wptr_r != rx_rptr_r);
    outstanding_s = tx_wptr_r - rx_wptr_r;
    cap_ok_s      = (tx_cap_cnt_r < remain_load_r);
    tx_acc_s      = 1'b0;
    tx_ovf_set_s  = 1'b0;
    rx_acc_s      = 1'b0;
    rx_orph_set_s = 1'b0;
    if (lat_enable && tx_mark && cap_ok_s) begin
      tx_acc_s     = !tx_full_s;
      tx_ovf_set_s = tx_full_s;
    end else begin
      tx_acc_s     = 1'b0;
      tx_ovf_set_s = 1'b0;
    end
    if (lat_enable && rx_mark) begin
      rx_acc_s      = (outstanding_s != {PW{1'b0}}) || tx_acc_s;
      rx_orph_set_s = !rx_acc_s;
    end else begin
      rx_acc_s      = 1'b0;
      rx_orph_set_s = 1'b0;
    end
    pop_acc_s = lat_pop && lat_valid && pair_avail_s;
  end

  // Stamp storage; stale contents are harmless because pointers define occupancy.
  always_ff @(posedge lat_clk) begin
    if (tx_acc_s) begin
      tx_mem_r[tx_wptr_r[AW-1:0]] <= timer_r;
    end
    if (rx_acc_s) begin
      rx_mem_r[rx_wptr_r[AW-1:0]] <= timer_r;
    end
  end

  // Timer, pointers, counters, sticky flags and the registered head pair.
  always_ff @(posedge lat_clk) begin
    if (lat_rst) begin
      timer_r       <= {TIMER_W{1'b0}};
      tx_wptr_r     <= {PW{1'b0}};
      tx_rptr_r     <= {PW{1'b0}};
      rx_wptr_r     <= {PW{1'b0}};
      rx_rptr_r     <= {PW{1'b0}};
      tx_cap_cnt_r  <= {CNT_W{1'b0}};
      remain_load_r <= {CNT_W{1'b0}};
      lat_remain    <= {CNT_W{1'b0}};
      lat_tx_ovf    <= 1'b0;
      lat_rx_orph   <= 1'b0;
      lat_valid     <= 1'b0;
      lat_tx_time   <= {TIMER_W{1'b0}};
      lat_rx_time   <= {TIMER_W{1'b0}};
    end else begin
      timer_r <= timer_r + TIMER_W'(1);
      if (lat_clear) begin
        tx_wptr_r     <= {PW{1'b0}};
        tx_rptr_r     <= {PW{1'b0}};
        rx_wptr_r     <= {PW{1'b0}};
        rx_rptr_r     <= {PW{1'b0}};
        tx_cap_cnt_r  <= {CNT_W{1'b0}};
        remain_load_r <= lat_target;
        lat_remain    <= lat_target;
        lat_tx_ovf    <= 1'b0;
        lat_rx_orph   <= 1'b0;
        lat_valid     <= 1'b0;
      end else begin
        if (tx_acc_s) begin
          tx_wptr_r    <= tx_wptr_r + PW'(1);
          tx_cap_cnt_r <= tx_cap_cnt_r + CNT_W'(1);
        end
        if (rx_acc_s) begin
          rx_wptr_r <= rx_wptr_r + PW'(1);
        end
        if (pop_acc_s) begin
          tx_rptr_r <= tx_rptr_r + PW'(1);
          rx_rptr_r <= rx_rptr_r + PW'(1);
          if (lat_remain != {CNT_W{1'b0}}) begin
            lat_remain <= lat_remain - CNT_W'(1);
          end
        end
        if (tx_ovf_set_s) begin
          lat_tx_ovf <= 1'b1;
        end
        if (rx_orph_set_s) begin
          lat_rx_orph <= 1'b1;
        end
        lat_valid <= pair_avail_s;
        if (pair_avail_s) begin
          lat_tx_time <= tx_mem_r[tx_rptr_r[AW-1:0]];
          lat_rx_time <= rx_mem_r[rx_rptr_r[AW-1:0]];
        end
      end
    end
  end

endmodule

// File: tb/tb_gtfraw_lat_stamp_fifo.sv
// Self-checking bench for gtfraw_lat_stamp_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_gtfraw_lat_stamp_fifo;

  localparam int DEPTH = 16;

  logic        lat_clk = 1'b0;
  logic        lat_rst = 1'b1;
  logic        lat_enable = 1'b0;
  logic        lat_clear = 1'b0;
  logic [15:0] lat_target = 16'd0;
  logic        tx_mark = 1'b0;
  logic        rx_mark = 1'b0;
  logic        lat_pop = 1'b0;
  logic [15:0] lat_tx_time;
  logic [15:0] lat_rx_time;
  logic        lat_valid;
  logic [15:0] lat_remain;
  logic        lat_tx_ovf;
  logic        lat_rx_orph;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] m_timer;
  logic [15:0] m_txq[$];
  logic [15:0] m_rxq[$];
  int          m_cap;
  int          m_loaded;
  logic [15:0] m_remain;
  logic        m_ovf;
  logic        m_orph;
  logic        m_valid;
  logic [15:0] m_tx_time;
  logic [15:0] m_rx_time;

  gtfraw_lat_stamp_fifo #(.DEPTH(DEPTH), .TIMER_W(16), .CNT_W(16)) dut (
    .lat_clk(lat_clk), .lat_rst(lat_rst), .lat_enable(lat_enable), .lat_clear(lat_clear),
    .lat_target(lat_target), .tx_mark(tx_mark), .rx_mark(rx_mark), .lat_pop(lat_pop),
    .lat_tx_time(lat_tx_time), .lat_rx_time(lat_rx_time), .lat_valid(lat_valid),
    .lat_remain(lat_remain), .lat_tx_ovf(lat_tx_ovf), .lat_rx_orph(lat_rx_orph)
  );

  always #5 lat_clk = ~lat_clk;

  task automatic model_edge();
    logic        nv;
    logic [15:0] htx, hrx, stamp;
    logic        pop_ok, cap_ok, tx_ok, rx_ok;
    int          outst;
    if (lat_rst) begin
      m_timer = 16'd0; m_txq.delete(); m_rxq.delete();
      m_cap = 0; m_loaded = 0; m_remain = 16'd0; m_ovf = 1'b0; m_orph = 1'b0;
      m_valid = 1'b0; m_tx_time = 16'd0; m_rx_time = 16'd0;
    end else begin
      nv = (m_txq.size() > 0) && (m_rxq.size() > 0);
      htx = nv ? m_txq[0] : 16'd0;
      hrx = nv ? m_rxq[0] : 16'd0;
      stamp = m_timer;
      m_timer = m_timer + 16'd1;
      if (lat_clear) begin
        m_txq.delete(); m_rxq.delete();
        m_cap = 0; m_loaded = int'(lat_target); m_remain = lat_target;
        m_ovf = 1'b0; m_orph = 1'b0; m_valid = 1'b0;
      end else begin
        pop_ok = lat_pop && m_valid && nv;
        cap_ok = m_cap < m_loaded;
        tx_ok  = tx_mark && lat_enable && cap_ok && (m_txq.size() < DEPTH);
        if (tx_mark && lat_enable && cap_ok && (m_txq.size() >= DEPTH)) m_ovf = 1'b1;
        outst = m_txq.size() - m_rxq.size();
        rx_ok = rx_mark && lat_enable && ((outst > 0) || tx_ok);
        if (rx_mark && lat_enable && !rx_ok) m_orph = 1'b1;
        if (pop_ok) begin
          void'(m_txq.pop_front());
          void'(m_rxq.pop_front());
          if (m_remain != 16'd0) m_remain = m_remain - 16'd1;
        end
        if (tx_ok) begin
          m_txq.push_back(stamp);
          m_cap = m_cap + 1;
        end
        if (rx_ok) m_rxq.push_back(stamp);
        m_valid = nv;
        if (nv) begin
          m_tx_time = htx;
          m_rx_time = hrx;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge lat_clk);
    model_edge();
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      if (lat_valid === 1'b1) ok = 1'b1;
      else step();
    end
  endtask

  task automatic do_clear(input logic [15:0] tgt);
    lat_target = tgt; lat_clear = 1'b1; step(); lat_clear = 1'b0;
  endtask

  task automatic test_reset();
    lat_rst = 1'b1;
    repeat (3) step();
    checks += 6;
    if (lat_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", lat_valid); end
    if (lat_remain !== 16'd0) begin errors++; $display("FAIL reset_remain got=%0d exp=0", lat_remain); end
    if (lat_tx_time !== 16'd0) begin errors++; $display("FAIL reset_tx_time got=%h exp=0", lat_tx_time); end
    if (lat_rx_time !== 16'd0) begin errors++; $display("FAIL reset_rx_time got=%h exp=0", lat_rx_time); end
    if (lat_tx_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", lat_tx_ovf); end
    if (lat_rx_orph !== 1'b0) begin errors++; $display("FAIL reset_orph got=%0b exp=0", lat_rx_orph); end
    lat_rst = 1'b0;
  endtask

  task automatic test_basic_pairs();
    bit ok;
    logic [15:0] d;
    do_clear(16'd10);
    lat_enable = 1'b1;
    checks++;
    if (lat_remain !== 16'd10) begin errors++; $display("FAIL basic_remain_load got=%0d exp=10", lat_remain); end
    for (int i = 0; i < 10; i++) begin
      tx_mark = 1'b1; step(); tx_mark = 1'b0;
      repeat (39) step();
      rx_mark = 1'b1; step(); rx_mark = 1'b0;
      wait_valid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_valid_timeout pair=%0d got=0 exp=1", i); end
      d = lat_rx_time - lat_tx_time;
      checks += 3;
      if (d !== 16'd40) begin errors++; $display("FAIL basic_latency pair=%0d got=%0d exp=40", i, d); end
      if (lat_tx_time !== m_tx_time) begin errors++; $display("FAIL basic_tx_time got=%h exp=%h", lat_tx_time, m_tx_time); end
      if (lat_remain !== 16'(10 - i)) begin errors++; $display("FAIL basic_remain_pre got=%0d exp=%0d", lat_remain, 10 - i); end
      lat_pop = 1'b1; step(); lat_pop = 1'b0;
      checks++;
      if (lat_remain !== 16'(9 - i)) begin errors++; $display("FAIL basic_remain_pop got=%0d exp=%0d", lat_remain, 9 - i); end
      step();
    end
    checks += 3;
    if (lat_valid !== 1'b0) begin errors++; $display("FAIL basic_end_valid got=%0b exp=0", lat_valid); end
    if (lat_tx_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%0b exp=0", lat_tx_ovf); end
    if (lat_rx_orph !== 1'b0) begin errors++; $display("FAIL basic_orph got=%0b exp=0", lat_rx_orph); end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [15:0] base;
    do_clear(16'd20);
    lat_enable = 1'b1;
    base = m_timer;
    tx_mark = 1'b1; repeat (17) step(); tx_mark = 1'b0;
    checks += 2;
    if (lat_tx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", lat_tx_ovf); end
    if (lat_valid !== 1'b0) begin errors++; $display("FAIL ovf_valid_no_rx got=%0b exp=0", lat_valid); end
    rx_mark = 1'b1; repeat (16) step(); rx_mark = 1'b0;
    checks++;
    if (lat_rx_orph !== 1'b0) begin errors++; $display("FAIL ovf_orph got=%0b exp=0", lat_rx_orph); end
    for (int i = 0; i < 16; i++) begin
      wait_valid(ok);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL ovf_valid_timeout idx=%0d got=0 exp=1", i); end
      if (lat_tx_time !== 16'(base + 16'(i))) begin
        errors++; $display("FAIL ovf_tx_stamp idx=%0d got=%h exp=%h", i, lat_tx_time, 16'(base + 16'(i)));
      end
      if (lat_rx_time !== 16'(base + 16'(17 + i))) begin
        errors++; $display("FAIL ovf_rx_stamp idx=%0d got=%h exp=%h", i, lat_rx_time, 16'(base + 16'(17 + i)));
      end
      lat_pop = 1'b1; step(); lat_pop = 1'b0;
      step();
    end
    repeat (2) step();
    checks += 2;
    if (lat_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid got=%0b exp=0", lat_valid); end
    if (lat_remain !== 16'd4) begin errors++; $display("FAIL ovf_remain got=%0d exp=4", lat_remain); end
  endtask

  task automatic test_orphan_and_same_cycle();
    bit ok;
    logic [15:0] stamp;
    do_clear(16'd5);
    rx_mark = 1'b1; step(); rx_mark = 1'b0;
    checks++;
    if (lat_rx_orph !== 1'b1) begin errors++; $display("FAIL orph_flag got=%0b exp=1", lat_rx_orph); end
    repeat (3) step();
    checks++;
    if (lat_valid !== 1'b0) begin errors++; $display("FAIL orph_valid got=%0b exp=0", lat_valid); end
    do_clear(16'd5);
    checks++;
    if (lat_rx_orph !== 1'b0) begin errors++; $display("FAIL orph_cleared got=%0b exp=0", lat_rx_orph); end
    stamp = m_timer;
    tx_mark = 1'b1; rx_mark = 1'b1; step(); tx_mark = 1'b0; rx_mark = 1'b0;
    wait_valid(ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL same_valid_timeout got=0 exp=1"); end
    if (lat_tx_time !== stamp) begin errors++; $display("FAIL same_tx got=%h exp=%h", lat_tx_time, stamp); end
    if (lat_rx_time !== stamp) begin errors++; $display("FAIL same_rx got=%h exp=%h", lat_rx_time, stamp); end
  endtask

  task automatic test_pop_and_clear();
    do_clear(16'd7);
    lat_pop = 1'b1; step(); lat_pop = 1'b0;
    step();
    checks += 2;
    if (lat_remain !== 16'd7) begin errors++; $display("FAIL idle_pop_remain got=%0d exp=7", lat_remain); end
    if (lat_valid !== 1'b0) begin errors++; $display("FAIL idle_pop_valid got=%0b exp=0", lat_valid); end
    tx_mark = 1'b1; lat_clear = 1'b1; step(); tx_mark = 1'b0; lat_clear = 1'b0;
    rx_mark = 1'b1; step(); rx_mark = 1'b0;
    checks += 2;
    if (lat_rx_orph !== 1'b1) begin errors++; $display("FAIL clear_wins_orph got=%0b exp=1", lat_rx_orph); end
    if (lat_remain !== 16'd7) begin errors++; $display("FAIL clear_wins_remain got=%0d exp=7", lat_remain); end
    repeat (3) step();
    checks++;
    if (lat_valid !== 1'b0) begin errors++; $display("FAIL clear_wins_valid got=%0b exp=0", lat_valid); end
  endtask

  task automatic test_random();
    do_clear(16'($urandom_range(5, 30)));
    lat_enable = 1'b1;
    for (int c = 0; c < 600; c++) begin
      tx_mark    = ($urandom_range(0, 5) == 0);
      rx_mark    = ($urandom_range(0, 4) == 0);
      lat_pop    = ($urandom_range(0, 7) == 0);
      lat_enable = ($urandom_range(0, 99) < 95);
      lat_target = 16'($urandom_range(3, 30));
      lat_clear  = ($urandom_range(0, 149) == 0);
      step();
      checks += 4;
      if (lat_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", c, lat_valid, m_valid); end
      if (lat_remain !== m_remain) begin errors++; $display("FAIL rnd_remain cyc=%0d got=%0d exp=%0d", c, lat_remain, m_remain); end
      if (lat_tx_ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", c, lat_tx_ovf, m_ovf); end
      if (lat_rx_orph !== m_orph) begin errors++; $display("FAIL rnd_orph cyc=%0d got=%0b exp=%0b", c, lat_rx_orph, m_orph); end
      if (m_valid) begin
        checks += 2;
        if (lat_tx_time !== m_tx_time) begin errors++; $display("FAIL rnd_tx cyc=%0d got=%h exp=%h", c, lat_tx_time, m_tx_time); end
        if (lat_rx_time !== m_rx_time) begin errors++; $display("FAIL rnd_rx cyc=%0d got=%h exp=%h", c, lat_rx_time, m_rx_time); end
      end
    end
    tx_mark = 1'b0; rx_mark = 1'b0; lat_pop = 1'b0; lat_clear = 1'b0; lat_enable = 1'b1;
  endtask

  task automatic test_wrap();
    bit ok;
    logic [15:0] d;
    do_clear(16'd10);
    lat_enable = 1'b1;
    for (int k = 0; k < 70000 && m_timer != 16'hFFF0; k++) step();
    tx_mark = 1'b1; step(); tx_mark = 1'b0;
    for (int k = 0; k < 64 && m_timer != 16'h0010; k++) step();
    rx_mark = 1'b1; step(); rx_mark = 1'b0;
    wait_valid(ok);
    d = lat_rx_time - lat_tx_time;
    checks += 4;
    if (!ok) begin errors++; $display("FAIL wrap_valid_timeout got=0 exp=1"); end
    if (lat_tx_time !== 16'hFFF0) begin errors++; $display("FAIL wrap_tx got=%h exp=fff0", lat_tx_time); end
    if (lat_rx_time !== 16'h0010) begin errors++; $display("FAIL wrap_rx got=%h exp=0010", lat_rx_time); end
    if (d !== 16'd32) begin errors++; $display("FAIL wrap_latency got=%0d exp=32", d); end
  endtask

  task automatic test_midrun_reset();
    do_clear(16'd10);
    lat_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_mark = 1'b1; step(); tx_mark = 1'b0;
      rx_mark = 1'b1; step(); rx_mark = 1'b0;
    end
    repeat (2) step();
    checks++;
    if (lat_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%0b exp=1", lat_valid); end
    lat_rst = 1'b1; step(); lat_rst = 1'b0;
    checks += 6;
    if (lat_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", lat_valid); end
    if (lat_remain !== 16'd0) begin errors++; $display("FAIL rst_remain got=%0d exp=0", lat_remain); end
    if (lat_tx_time !== 16'd0) begin errors++; $display("FAIL rst_tx got=%h exp=0", lat_tx_time); end
    if (lat_rx_time !== 16'd0) begin errors++; $display("FAIL rst_rx got=%h exp=0", lat_rx_time); end
    if (lat_tx_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%0b exp=0", lat_tx_ovf); end
    if (lat_rx_orph !== 1'b0) begin errors++; $display("FAIL rst_orph got=%0b exp=0", lat_rx_orph); end
    do_clear(16'd4);
    rx_mark = 1'b1; step(); rx_mark = 1'b0;
    checks++;
    if (lat_rx_orph !== 1'b1) begin errors++; $display("FAIL rst_flushed_orph got=%0b exp=1", lat_rx_orph); end
  endtask

  initial begin
    test_reset();
    test_basic_pairs();
    test_overflow();
    test_orphan_and_same_cycle();
    test_pop_and_clear();
    test_random();
    test_wrap();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
